// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK frame sequencer: FSM state encoding and default framing words.
package bpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GUARD    = 2'd3
  } state_e;

  localparam logic [11:0] DEF_PREAMBLE  = 12'hA5A;
  localparam logic [11:0] DEF_IDLE_WORD = 12'h000;

endpackage

// File: rtl/bpsk_tx_scheduler_if.sv
// Payload word stream into the BPSK frame sequencer (valid/ready, transfer when both high).
interface bpsk_tx_scheduler_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/bpsk_symbol_timer.sv
// Symbol grid tracker: samples per bit and bits per word, flagging the last clock of each word.
module bpsk_symbol_timer #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int DATA_WIDTH    = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic word_end
);

  localparam int SW = (SAMPLE_NUMBER > 1) ? $clog2(SAMPLE_NUMBER) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          samp_last, bit_last;

  assign samp_last = (samp_cnt_q == SW'(SAMPLE_NUMBER - 1));
  assign bit_last  = (bit_cnt_q == BW'(DATA_WIDTH - 1));
  assign word_end  = en & samp_last & bit_last;

  // Sample counter wraps on its own (power-of-2 depth); bit counter wraps explicitly.
  always_comb begin
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr) begin
      samp_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (en) begin
      samp_cnt_d = samp_cnt_q + SW'(1);
      if (samp_last) begin
        bit_cnt_d = bit_last ? '0 : bit_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Frame sequencer ahead of the BPSK modulator: preamble, frame_len payload words, then a guard gap.
//
//  state       | meaning
//  ST_IDLE     | waiting for start, modulator off
//  ST_PREAMBLE | sending the preamble word
//  ST_PAYLOAD  | sending payload words (IDLE_WORD on underrun)
//  ST_GUARD    | modulator off, counting the guard gap
module bpsk_tx_scheduler
  import bpsk_pkg::*;
#(
  parameter int                    SAMPLE_NUMBER = 256,
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    LEN_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE      = DATA_WIDTH'(DEF_PREAMBLE),
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DATA_WIDTH'(DEF_IDLE_WORD),
  parameter int                    GUARD_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  bpsk_tx_scheduler_if.slave    s_if,
  output logic                  mod_en,
  output logic [DATA_WIDTH-1:0] mod_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
  logic [GW-1:0]         guard_q, guard_d;
  logic                  mod_en_q, mod_en_d;
  logic [DATA_WIDTH-1:0] mod_data_q, mod_data_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  underrun_q, underrun_d;
  logic                  timer_clr, word_end, fetch;

  bpsk_symbol_timer #(
    .SAMPLE_NUMBER(SAMPLE_NUMBER),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (mod_en_q),
    .clr     (timer_clr),
    .word_end(word_end)
  );

  // A fetch slot exists only at a word boundary with frame words still owed.
  assign fetch = word_end & (words_left_q != '0) &
                 ((state_q == ST_PREAMBLE) | (state_q == ST_PAYLOAD));
  assign s_if.s_ready = fetch & s_if.s_valid & ~rst;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    guard_d      = guard_q;
    mod_en_d     = mod_en_q;
    mod_data_d   = mod_data_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;
    timer_clr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_left_d = frame_len;
          underrun_d   = 1'b0;
          mod_data_d   = PREAMBLE;
          mod_en_d     = 1'b1;
          timer_clr    = 1'b1;
          state_d      = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE, ST_PAYLOAD: begin
        if (word_end) begin
          if (words_left_q == '0) begin
            mod_en_d = 1'b0;
            guard_d  = GW'(GUARD_CYCLES - 1);
            state_d  = ST_GUARD;
          end else begin
            mod_data_d   = s_if.s_valid ? s_if.s_data : IDLE_WORD;
            underrun_d   = underrun_q | ~s_if.s_valid;
            words_left_d = words_left_q - LEN_WIDTH'(1);
            state_d      = ST_PAYLOAD;
          end
        end
      end
      ST_GUARD: begin
        if (guard_q == '0) begin
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      guard_q      <= '0;
      mod_en_q     <= 1'b0;
      mod_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      guard_q      <= guard_d;
      mod_en_q     <= mod_en_d;
      mod_data_q   <= mod_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign mod_en     = mod_en_q;
  assign mod_data   = mod_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Bench for bpsk_tx_scheduler: frame-timeline reference model, per-cycle compare, directed and random frames.
module tb_bpsk_tx_scheduler;

  localparam int SN = 4, DW = 4, LW = 8, GC = 3;
  localparam int WORD = SN * DW;
  localparam logic [DW-1:0] PRE = 4'hA, IDW = 4'h0;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, mod_en, busy, frame_done, underrun;
  logic [DW-1:0] mod_data;

  bpsk_tx_scheduler_if #(.DATA_WIDTH(DW)) sif ();
  assign sif.s_valid = s_valid;
  assign sif.s_data  = s_data;
  assign s_ready     = sif.s_ready;

  bpsk_tx_scheduler #(
    .SAMPLE_NUMBER(SN), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .PREAMBLE(PRE), .IDLE_WORD(IDW), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .s_if(sif),
    .mod_en(mod_en), .mod_data(mod_data), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: position inside the frame timeline, m_t = clocks since the start edge.
  bit            m_active = 0;
  int            m_t = 0, m_len = 0;
  logic          e_en = 0, e_busy = 0, e_done = 0, e_und = 0, e_ready;
  logic [DW-1:0] e_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_t = 0; e_en = 0; e_data = '0; e_busy = 0; e_done = 0; e_und = 0;
    end else begin
      e_done = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_len = int'(frame_len); m_t = 1;
          e_en = 1; e_busy = 1; e_data = PRE; e_und = 0;
        end
      end else begin
        if (m_t % WORD == 0 && m_t < (1 + m_len) * WORD) begin
          if (s_valid) e_data = s_data;
          else begin e_data = IDW; e_und = 1; end
        end
        if (m_t == (1 + m_len) * WORD) e_en = 0;
        if (m_t == (1 + m_len) * WORD + GC) begin
          e_done = 1; e_busy = 0; m_active = 0;
        end
        m_t++;
      end
    end
  end

  // Per-frame observations and stream source state.
  int            en_cnt = 0, rdy_cnt = 0, done_cnt = 0;
  logic [DW-1:0] words_q[$];
  logic [DW-1:0] src_q[$];
  int            valid_pct = 100, skip_t = 0;
  bit            force_valid = 0, pop_pend = 0, chk_on = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      e_ready = m_active && (m_t % WORD == 0) && (m_t < (1 + m_len) * WORD) && s_valid && !rst;
      tests++;
      if ({mod_en, mod_data, busy, frame_done, underrun, s_ready} !==
          {e_en, e_data, e_busy, e_done, e_und, e_ready}) begin
        fails++;
        $display("FAIL cycle_cmp @%0t en/data/busy/done/und/rdy got %b/%h/%b/%b/%b/%b expected %b/%h/%b/%b/%b/%b",
                 $time, mod_en, mod_data, busy, frame_done, underrun, s_ready,
                 e_en, e_data, e_busy, e_done, e_und, e_ready);
      end
    end
    if (mod_en === 1'b1) begin
      if (en_cnt % WORD == 0) words_q.push_back(mod_data);
      en_cnt++;
    end
    if (s_ready === 1'b1) rdy_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (s_valid && s_ready === 1'b1 && !force_valid) pop_pend = 1;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      if (src_q.size() > 0) void'(src_q.pop_front());
      pop_pend = 0;
    end
    if (force_valid) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
    end else if (src_q.size() > 0 && !(skip_t != 0 && m_active && m_t == skip_t) &&
                 $urandom_range(99) < valid_pct) begin
      s_valid = 1'b1;
      s_data  = src_q[0];
    end else begin
      s_valid = 1'b0;
      s_data  = DW'($urandom);
    end
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int word_at(int i);
    return (words_q.size() > i) ? int'(words_q[i]) : -1;
  endfunction

  task automatic clear_stats();
    en_cnt = 0; rdy_cnt = 0; done_cnt = 0;
    words_q.delete();
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int len);
    start = 1'b1;
    frame_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    frame_len = LW'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin @(posedge clk); n++; end
    #1;
    chk("frame_done_seen", int'(done_cnt > 0), 1);
    cycles(2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_active || busy !== 1'b0) && n < 3000) begin @(posedge clk); n++; end
    #1;
    chk("idle_reached", int'(busy), 0);
    cycles(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    rst = 1'b0;
    chk_on = 1;
    chk("reset_mod_en", int'(mod_en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_mod_data", int'(mod_data), 0);
    chk("reset_underrun", int'(underrun), 0);

    // 1: two payload words, source always ready
    clear_stats(); src_q = '{4'h3, 4'hC}; valid_pct = 100;
    pulse_start(2);
    wait_done();
    chk("t1_en_cycles", en_cnt, 48);
    chk("t1_ready_pulses", rdy_cnt, 2);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_word0", word_at(0), 'hA);
    chk("t1_word1", word_at(1), 'h3);
    chk("t1_word2", word_at(2), 'hC);
    chk("t1_underrun", int'(underrun), 0);

    // 2: preamble only
    clear_stats(); src_q.delete();
    pulse_start(0);
    wait_done();
    chk("t2_en_cycles", en_cnt, 16);
    chk("t2_ready_pulses", rdy_cnt, 0);
    chk("t2_word0", word_at(0), 'hA);
    chk("t2_underrun", int'(underrun), 0);

    // 3: second fetch finds no data
    clear_stats(); src_q = '{4'h5, 4'h6}; skip_t = 2 * WORD;
    pulse_start(3);
    wait_done();
    skip_t = 0;
    chk("t3_en_cycles", en_cnt, 64);
    chk("t3_word1", word_at(1), 'h5);
    chk("t3_word2", word_at(2), 'h0);
    chk("t3_word3", word_at(3), 'h6);
    chk("t3_underrun", int'(underrun), 1);
    cycles(5);
    chk("t3_underrun_sticky", int'(underrun), 1);

    // 4: start during payload is ignored
    clear_stats(); src_q = '{4'h1, 4'h2, 4'h3};
    pulse_start(3);
    chk("t4_underrun_cleared", int'(underrun), 0);
    cycles(30);
    pulse_start(1);
    chk("t4_busy_held", int'(busy), 1);
    wait_done();
    cycles(5);
    chk("t4_done_pulses", done_cnt, 1);
    chk("t4_en_cycles", en_cnt, 64);
    chk("t4_busy_after", int'(busy), 0);

    // 5: reset mid-payload, then a clean frame
    clear_stats(); src_q = '{4'h9, 4'h9, 4'h9};
    pulse_start(3);
    cycles(25);
    rst = 1'b1;
    cycles(1);
    chk("t5_rst_mod_en", int'(mod_en), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_mod_data", int'(mod_data), 0);
    chk("t5_rst_ready", int'(s_ready), 0);
    rst = 1'b0;
    src_q.delete();
    cycles(2);
    clear_stats(); src_q = '{4'h7};
    pulse_start(1);
    wait_done();
    chk("t5_word0", word_at(0), 'hA);
    chk("t5_word1", word_at(1), 'h7);
    chk("t5_en_cycles", en_cnt, 32);

    // 6: valid held high outside fetch slots
    clear_stats(); force_valid = 1;
    cycles(10);
    chk("t6_idle_ready", rdy_cnt, 0);
    pulse_start(1);
    wait_done();
    cycles(5);
    chk("t6_ready_pulses", rdy_cnt, 1);
    force_valid = 0;
    cycles(2);

    // Random frames with underruns, stray starts and mid-frame resets
    for (int i = 0; i < 25; i++) begin
      int len, mode;
      clear_stats(); src_q.delete();
      len = $urandom_range(0, 4);
      for (int k = 0; k < len; k++) src_q.push_back(DW'($urandom));
      valid_pct = $urandom_range(50, 100);
      pulse_start(len);
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        cycles($urandom_range(1, 60));
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end else if (mode == 1) begin
        cycles($urandom_range(1, 60));
        pulse_start($urandom_range(0, 2));
      end
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
